timer_interrupt_controller: RTL
===============================

Name: timer_interrupt_controller

Overview:
- Consumer end of the timer flag interface: takes TIFR and TIMSK from the Timer0/1/2 register blocks and raises one prioritised interrupt request to the CPU core, with a vector.
- After the CPU acknowledges, it performs the hardware clear of the serviced TIFR flag through the timer's TIFR write port, then waits for RETI before arbitrating again.
- Sits between the timer register blocks and the CPU control unit.

Parameters:
- VECTOR_BASE, 8'h08, word address of the highest-priority timer vector (TIMER2 COMP).
- VECTOR_STEP, 2, address increment per priority level.
- ACK_TIMEOUT, 64, cycles allowed in REQ before timeout. Used only with TIMER_IRQ_TIMEOUT_EN.

Ports:
- sysClock  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- TIFR_input  in  8  live TIFR value (b7 OCF2, b6 TOV2, b5 ICF1, b4 OCF1A, b3 OCF1B, b2 TOV1, b1 OCF0, b0 TOV0).
- TIMSK_input  in  8  live TIMSK value, same bit map.
- global_int_enable  in  1  SREG I bit.
- irq_ack  in  1  single-cycle pulse from the CPU: vector fetch taken.
- reti  in  1  single-cycle pulse from the CPU: RETI executed.
- irq  out  1  interrupt request to the CPU.
- irq_vector  out  8  vector word address, valid while irq=1.
- TIFR_output  out  8  data for TIFR hardware clear.
- TIFR_write_enable  out  1  one-cycle TIFR write strobe.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky error flag; exists only with TIMER_IRQ_TIMEOUT_EN.

Behaviour:
- Pending vector: pending = TIFR_input & TIMSK_input.
- Priority: bit7 is highest, bit0 is lowest.
  - Index idx = 7 − bit position.
  - irq_vector = VECTOR_BASE + idx*VECTOR_STEP, truncated to 8 bits.
  - Defaults give b7→8'h08 … b0→8'h16.
- Reset (rst=1 at an edge): state=IDLE. irq, irq_vector, TIFR_output, TIFR_write_enable, busy and timeout_err are all 0. Reset mid-service abandons the service; no TIFR write is issued.
- IDLE:
  - If global_int_enable=1 and pending≠0, latch the highest-priority bit position (sel) and go to REQ.
  - irq and irq_vector are registered, so they rise the cycle after the flag is sampled (latency 1 cycle).
- REQ:
  - irq=1 and irq_vector is held stable. The selection is locked; a higher-priority flag arriving in REQ does not preempt.
  - irq_ack=1 → CLEAR.
  - Withdraw to IDLE (irq low the next cycle, no TIFR write) if either happens before ack:
    - global_int_enable falls to 0;
    - pending[sel] becomes 0 (software cleared the flag or TIMSK).
  - If ack and withdraw conditions occur in the same cycle, ack wins.
- CLEAR:
  - Lasts exactly one cycle. irq=0.
  - TIFR_write_enable=1 and TIFR_output = TIFR_input & ~(1<<sel), computed combinationally from the current cycle's TIFR_input. Other flags set in this same cycle are therefore preserved.
  - Next state is SERVICE.
- SERVICE: irq=0. Wait for reti=1, then go to IDLE. Because IDLE re-arbitrates, back-to-back requests are separated by at least one IDLE cycle.
- irq_ack outside REQ is ignored. reti outside SERVICE is ignored.
- TIFR_output is 8'h00 whenever TIFR_write_enable=0.

Optional Feature:
- TIMER_IRQ_TIMEOUT_EN defined:
  - An 8-bit cycle counter is cleared on entry to REQ and increments each cycle spent in REQ.
  - On reaching ACK_TIMEOUT with no ack: withdraw to IDLE, and set timeout_err=1, which remains set until rst.
  - Ack in the same cycle as the timeout counts as ack; no error is raised.
- TIMER_IRQ_TIMEOUT_EN undefined: REQ waits indefinitely, and the timeout_err port and counter are absent.

Test Plan:
- Single request: TIMSK=8'h04, global_int_enable=1, TIFR=8'h04 asserted at cycle N → irq=1 with irq_vector=8'h12 at N+1. Ack pulse → one cycle with TIFR_write_enable=1 and TIFR_output=8'h00. reti → busy=0.
- Priority: TIFR=8'h11, TIMSK=8'hFF → irq_vector=8'h0E (OCF1A). CLEAR writes 8'h01. After reti, a second request follows with vector 8'h16.
- Masking and I bit: TIFR=8'hFF, TIMSK=8'h00 → irq stays 0. TIMSK=8'h01 with global_int_enable=0 → irq stays 0. Raising global_int_enable → vector 8'h16.
- Withdraw: in REQ, clear TIFR bit sel externally → irq=0 the next cycle, no TIFR_write_enable pulse, busy=0.
- Concurrent flag: in the CLEAR cycle TIFR_input=8'h05 with sel=b2 → TIFR_output=8'h01, so TOV0 is preserved.
- Reset in SERVICE: rst pulse → all outputs 0 and state IDLE. With TIMER_IRQ_TIMEOUT_EN, holding ack low for 64 cycles → irq drops and timeout_err=1.

Source files
------------

// File: rtl/timer_interrupt_controller.sv
// Prioritised timer interrupt controller: arbitrates TIFR&TIMSK, requests the CPU, clears the flag on ack, waits for RETI.
// Optional request timeout with sticky error flag is enabled by defining TIMER_IRQ_TIMEOUT_EN.
module timer_interrupt_controller #(
  parameter logic [7:0] VECTOR_BASE = 8'h08,
  parameter int         VECTOR_STEP = 2
`ifdef TIMER_IRQ_TIMEOUT_EN
  , parameter int       ACK_TIMEOUT = 64
`endif
) (
  input  logic       sysClock,
  input  logic       rst,
  input  logic [7:0] TIFR_input,
  input  logic [7:0] TIMSK_input,
  input  logic       global_int_enable,
  input  logic       irq_ack,
  input  logic       reti,
  output logic       irq,
  output logic [7:0] irq_vector,
  output logic [7:0] TIFR_output,
  output logic       TIFR_write_enable,
  output logic       busy
`ifdef TIMER_IRQ_TIMEOUT_EN
  , output logic     timeout_err
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    CLEAR   = 2'd2,
    SERVICE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] vector_q, vector_d;
  logic [7:0] pending;
  logic [2:0] selCand;
  logic [7:0] vectorCand;

`ifdef TIMER_IRQ_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  // Ascending scan so the highest set bit is the one left in selCand.
  always_comb begin
    pending = TIFR_input & TIMSK_input;
    selCand = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pending[i]) selCand = 3'(i);
    end
    vectorCand = 8'(int'(VECTOR_BASE) + (7 - int'(selCand)) * VECTOR_STEP);
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    vector_d = vector_q;
`ifdef TIMER_IRQ_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (global_int_enable && (pending != 8'h00)) begin
          state_d  = REQ;
          sel_d    = selCand;
          vector_d = vectorCand;
`ifdef TIMER_IRQ_TIMEOUT_EN
          cnt_d    = 8'd0;
`endif
        end
      end
      REQ: begin
        // Ack takes precedence over both withdraw and timeout.
        if (irq_ack) begin
          state_d = CLEAR;
        end else if (!global_int_enable || !pending[sel_q]) begin
          state_d = IDLE;
        end
`ifdef TIMER_IRQ_TIMEOUT_EN
        else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      CLEAR: begin
        state_d = SERVICE;
      end
      SERVICE: begin
        if (reti) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sysClock) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 3'd0;
      vector_q <= 8'h00;
`ifdef TIMER_IRQ_TIMEOUT_EN
      cnt_q    <= 8'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      vector_q <= vector_d;
`ifdef TIMER_IRQ_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Outputs decode registered state; only the clear data follows live TIFR so concurrent flags survive.
  always_comb begin
    irq               = 1'b0;
    irq_vector        = 8'h00;
    TIFR_write_enable = 1'b0;
    TIFR_output       = 8'h00;
    busy              = (state_q != IDLE);
    if (state_q == REQ) begin
      irq        = 1'b1;
      irq_vector = vector_q;
    end
    if (state_q == CLEAR) begin
      TIFR_write_enable = 1'b1;
      TIFR_output       = TIFR_input & ~(8'h01 << sel_q);
    end
  end

`ifdef TIMER_IRQ_TIMEOUT_EN
  assign timeout_err = err_q;
`endif

endmodule
